// File: rtl/vid_itc_stream_out.sv
// vid_itc_stream_out: clocked-video output block. Buffers a packetised pixel
// stream in a small FIFO and generates programmable LCD timing (syncs,
// blanking, data-valid) on one pixel clock. Frames lock on the sop-marked word
// at counter position (0,0); a sticky, clearable underflow flag reports starvation.
// Optional build macro VID_ITC_TPG_EN: unlocked and underflow active pixels show
// 8 vertical colour bars instead of black.
module vid_itc_stream_out #(
    parameter int BPS        = 8,
    parameter int CHANNELS   = 3,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 48,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 29,
    parameter int FIFO_DEPTH = 16,
    parameter int SYNC_POL   = 0
) (
    input  logic                       vid_clk,
    input  logic                       reset_n,
    input  logic [BPS*CHANNELS-1:0]    in_data,
    input  logic                       in_valid,
    input  logic                       in_sop,
    output logic                       in_ready,
    output logic [BPS*CHANNELS-1:0]    vid_data,
    output logic                       vid_datavalid,
    output logic                       vid_h_sync,
    output logic                       vid_v_sync,
    output logic                       vid_h,
    output logic                       vid_v,
    output logic                       vid_f,
    input  logic                       underflow_clr,
    output logic                       underflow
);

    localparam int DATA_W  = BPS * CHANNELS;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SS_C   = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SE_C   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] H_LAST_C = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SS_C   = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SE_C   = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] V_LAST_C = VCW'(V_TOTAL - 1);
    localparam logic [AW:0]    FULL_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic           SYNC_ON  = 1'(SYNC_POL);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [HCW-1:0]    h_cnt_q;
    logic [VCW-1:0]    v_cnt_q;
    logic [0:0]        state_q, state_d;
    logic [DATA_W:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q, count;
    logic              rdy_en_q, full, empty, push, pop;
    logic              head_sop, active, at_origin, uf_set;
    logic [DATA_W-1:0] head_data, fill, pix_d;
    logic [DATA_W-1:0] vid_data_q;
    logic              dv_q, hs_q, vs_q, hb_q, vb_q, uf_q;

`ifdef VID_ITC_TPG_EN
    // Eight vertical bars across the active width; channel 0 is the most
    // significant field, channel c lights when bit c of the bar index is set.
    function automatic logic [DATA_W-1:0] tpg_pixel(input logic [HCW-1:0] h);
        int                bar;
        logic [DATA_W-1:0] px;
        bar = (int'(h) * 8) / H_ACTIVE;
        px  = '0;
        for (int c = 0; c < CHANNELS && c < 3; c++) begin
            if (bar[c]) px[(CHANNELS-1-c)*BPS +: BPS] = '1;
        end
        return px;
    endfunction

    assign fill = tpg_pixel(h_cnt_q);
`else
    assign fill = '0;
`endif

    assign count     = wr_ptr_q - rd_ptr_q;
    assign full      = (count == FULL_C);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign in_ready  = rdy_en_q && !full;
    assign push      = in_valid && in_ready;
    assign head_sop  = mem_q[rd_ptr_q[AW-1:0]][DATA_W];
    assign head_data = mem_q[rd_ptr_q[AW-1:0]][DATA_W-1:0];
    assign active    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);

    // Pixel source selection: frame locking in SYNC, one pop per active pixel in RUN.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        uf_set  = 1'b0;
        pix_d   = '0;
        if (state_q == ST_SYNC) begin
            if (active) pix_d = fill;
            if (!empty && !head_sop) begin
                pop = 1'b1;
            end else if (!empty && at_origin) begin
                pop     = 1'b1;
                pix_d   = head_data;
                state_d = ST_RUN;
            end
        end else if (active) begin
            if (empty) begin
                pix_d   = fill;
                uf_set  = 1'b1;
                state_d = ST_SYNC;
            end else if (head_sop && !at_origin) begin
                state_d = ST_SYNC;
            end else begin
                pop   = 1'b1;
                pix_d = head_data;
            end
        end
    end

    // Raster counters: h wraps every line, v advances on each h wrap.
    always_ff @(posedge vid_clk) begin
        if (!reset_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= (h_cnt_q == H_LAST_C) ? '0 : h_cnt_q + HCW'(1);
            if (h_cnt_q == H_LAST_C)
                v_cnt_q <= (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + VCW'(1);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge vid_clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_sop, in_data};
    end

    // FIFO pointers, ready enable, lock state and sticky underflow.
    always_ff @(posedge vid_clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_en_q <= 1'b0;
            state_q  <= ST_SYNC;
            uf_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + (AW+1)'(push);
            rd_ptr_q <= rd_ptr_q + (AW+1)'(pop);
            rdy_en_q <= 1'b1;
            state_q  <= state_d;
            if (uf_set)             uf_q <= 1'b1;
            else if (underflow_clr) uf_q <= 1'b0;
        end
    end

    // Output registers: pins follow the counter position by one clock.
    always_ff @(posedge vid_clk) begin
        if (!reset_n) begin
            vid_data_q <= '0;
            dv_q       <= 1'b0;
            hs_q       <= ~SYNC_ON;
            vs_q       <= ~SYNC_ON;
            hb_q       <= 1'b0;
            vb_q       <= 1'b0;
        end else begin
            vid_data_q <= pix_d;
            dv_q       <= active;
            hs_q       <= ((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C)) ? SYNC_ON : ~SYNC_ON;
            vs_q       <= ((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C)) ? SYNC_ON : ~SYNC_ON;
            hb_q       <= (h_cnt_q >= H_ACT_C);
            vb_q       <= (v_cnt_q >= V_ACT_C);
        end
    end

    assign vid_data      = vid_data_q;
    assign vid_datavalid = dv_q;
    assign vid_h_sync    = hs_q;
    assign vid_v_sync    = vs_q;
    assign vid_h         = hb_q;
    assign vid_v         = vb_q;
    assign vid_f         = 1'b0;
    assign underflow     = uf_q;

endmodule

// File: tb/tb_vid_itc_stream_out.sv
// tb_vid_itc_stream_out: randomized scoreboard bench for vid_itc_stream_out on
// a tiny raster (7 clocks/line, 5 lines/frame, 4-entry FIFO). A reference
// model derives each cycle's expected pins from the raster position and a
// queue of accepted words; a monitor compares them one clock later.
module tb_vid_itc_stream_out;

  localparam int BPS = 8, CH = 3, DW = BPS * CH;
  localparam int HA = 4, HFP = 1, HSW = 1, HBP = 1;
  localparam int VA = 2, VFP = 1, VSW = 1, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int DEPTH = 4;
  localparam logic SP = 1'b0;
  localparam int TIMEOUT_NS = 200000;

  typedef struct packed {
    logic [DW-1:0] data;
    logic dv, hs, vs, h, v, f, uf, rdy;
  } exp_t;

  logic          vid_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_sop = 1'b0, underflow_clr = 1'b0;
  logic          in_ready, vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v, vid_f, underflow;
  logic [DW-1:0] vid_data;

  vid_itc_stream_out #(
    .BPS(BPS), .CHANNELS(CH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .FIFO_DEPTH(DEPTH), .SYNC_POL(0)
  ) dut (
    .vid_clk(vid_clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_ready(in_ready),
    .vid_data(vid_data), .vid_datavalid(vid_datavalid),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
    .vid_h(vid_h), .vid_v(vid_v), .vid_f(vid_f),
    .underflow_clr(underflow_clr), .underflow(underflow)
  );

  always #5 vid_clk = ~vid_clk;

  exp_t          exp_q[$];
  logic [DW:0]   tx_q[$];     // words the source still has to deliver
  logic [DW:0]   mq[$];       // model: words accepted, not yet consumed
  int            t_pos = 0;   // model: raster position index within a frame
  bit            locked = 0, muf = 0, m_rdy = 0;
  bit            rand_vld = 0, rand_clr = 0, src_acc = 0;
  bit            done = 0;
  int            vectors = 0, miscompares = 0;

  // Colour bars when the pattern generator is built in, black otherwise.
  function automatic logic [DW-1:0] filler(input int h);
`ifdef VID_ITC_TPG_EN
    int bar;
    bar = h * 8 / HA;
    return {((bar & 1) != 0) ? 8'hFF : 8'h00,
            ((bar & 2) != 0) ? 8'hFF : 8'h00,
            ((bar & 4) != 0) ? 8'hFF : 8'h00};
`else
    return (h < 0) ? '1 : '0;
`endif
  endfunction

  task automatic model_step();
    exp_t        e;
    int          h, v;
    bit          act, set;
    logic [DW:0] w;
    if (!reset_n) begin
      t_pos = 0; mq.delete(); locked = 0; muf = 0;
      e = '{data: '0, dv: 1'b0, hs: ~SP, vs: ~SP, h: 1'b0, v: 1'b0, f: 1'b0, uf: 1'b0, rdy: 1'b0};
    end else begin
      h = t_pos % HT;
      v = t_pos / HT;
      act = (h < HA) && (v < VA);
      set = 0;
      e.data = '0;
      if (!locked) begin
        if (act) e.data = filler(h);
        if (mq.size() > 0 && !mq[0][DW]) begin
          w = mq.pop_front();
        end else if (mq.size() > 0 && h == 0 && v == 0) begin
          w = mq.pop_front();
          e.data = w[DW-1:0];
          locked = 1;
        end
      end else if (act) begin
        if (mq.size() == 0) begin
          e.data = filler(h); set = 1; locked = 0;
        end else if (mq[0][DW] && !(h == 0 && v == 0)) begin
          locked = 0;
        end else begin
          w = mq.pop_front();
          e.data = w[DW-1:0];
        end
      end
      if (in_valid && m_rdy) mq.push_back({in_sop, in_data});
      if (set) muf = 1;
      else if (underflow_clr) muf = 0;
      e.dv  = act;
      e.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? SP : ~SP;
      e.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? SP : ~SP;
      e.h   = (h >= HA);
      e.v   = (v >= VA);
      e.f   = 1'b0;
      e.uf  = muf;
      e.rdy = (mq.size() < DEPTH);
      t_pos = (t_pos + 1) % (HT * VT);
    end
    m_rdy = e.rdy;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, predict the edge, advance past it.
  task automatic tick();
    in_valid = (tx_q.size() > 0) && (!rand_vld || $urandom_range(3) != 0);
    if (tx_q.size() > 0) {in_sop, in_data} = tx_q[0];
    else {in_sop, in_data} = '0;
    if (rand_clr) underflow_clr = ($urandom_range(7) == 0);
    src_acc = in_valid && in_ready && reset_n;
    model_step();
    @(posedge vid_clk);
    #2;
    if (src_acc) void'(tx_q.pop_front());
    if (!reset_n) tx_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_frame(input int n, input bit seq, input int base);
    for (int i = 0; i < n; i++)
      tx_q.push_back({(i == 0), seq ? DW'(base + i) : DW'($urandom)});
  endtask

  // Monitor: every output sample is checked against the oldest prediction.
  always @(negedge vid_clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{data: vid_data, dv: vid_datavalid, hs: vid_h_sync, vs: vid_v_sync,
            h: vid_h, v: vid_v, f: vid_f, uf: underflow, rdy: in_ready};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL pins @%0t: got data=%h dv=%b hs=%b vs=%b h=%b v=%b f=%b uf=%b rdy=%b, want data=%h dv=%b hs=%b vs=%b h=%b v=%b f=%b uf=%b rdy=%b",
                 $time, a.data, a.dv, a.hs, a.vs, a.h, a.v, a.f, a.uf, a.rdy,
                 e.data, e.dv, e.hs, e.vs, e.h, e.v, e.f, e.uf, e.rdy);
      end
    end
  end

  initial begin
    #(TIMEOUT_NS);
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: stimulus did not complete within %0d ns", TIMEOUT_NS);
      $finish;
    end
  end

  initial begin
    reset_n = 1'b0;
    run(3);
    if (vid_data !== '0 || vid_datavalid !== 1'b0 || vid_h !== 1'b0 || vid_v !== 1'b0 ||
        vid_f !== 1'b0 || underflow !== 1'b0 || in_ready !== 1'b0 ||
        vid_h_sync !== ~SP || vid_v_sync !== ~SP) begin
      miscompares++;
      $display("FAIL reset state @%0t: data=%h dv=%b hs=%b vs=%b h=%b v=%b f=%b uf=%b rdy=%b",
               $time, vid_data, vid_datavalid, vid_h_sync, vid_v_sync,
               vid_h, vid_v, vid_f, underflow, in_ready);
    end
    reset_n = 1'b1;
    run(70);
    send_frame(8, 1, 1);
    run(75);
    send_frame(5, 1, 16);
    run(75);
    underflow_clr = 1'b1; run(1); underflow_clr = 1'b0;
    run(5);
    send_frame(5, 1, 32);
    underflow_clr = 1'b1; run(75);
    underflow_clr = 1'b0; run(5);
    for (int i = 0; i < 3; i++) tx_q.push_back({1'b0, DW'(100 + i)});
    send_frame(8, 1, 48);
    run(75);
    rand_vld = 1; rand_clr = 1;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(1) == 1)
        for (int j = 0; j < int'($urandom_range(3)); j++) tx_q.push_back({1'b0, DW'($urandom)});
      send_frame($urandom_range(10, 3), 0, 0);
      run($urandom_range(60, 20));
      if (k == 4) begin
        reset_n = 1'b0; run(2); reset_n = 1'b1;
      end
    end
    rand_vld = 0; rand_clr = 0; underflow_clr = 1'b0;
    run(10);
    @(negedge vid_clk);
    #1;
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else $display("FAIL: %0d miscompares", miscompares);
    $finish;
  end

endmodule
